// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the MixColumns stage.
// The coefficient vectors pack four 4-bit multipliers, row-0 coefficient in the MSB nibble.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;
  typedef logic [15:0]  coef_set_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mix_state_e;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam coef_set_t  MIX_FWD  = {4'd2, 4'd3, 4'd1, 4'd1};
  localparam coef_set_t  MIX_INV  = {4'd14, 4'd11, 4'd13, 4'd9};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a constant below 16: XOR of the selected a*2^i terms.
  function automatic logic [7:0] gf_mul4(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

endpackage

// File: rtl/mix_col_word.sv
// Combinational MixColumns on one 32-bit column: 16 constant multipliers plus an XOR tree.
// Row r uses coefficient k on byte (r+k) mod 4, so one coefficient set covers the circulant matrix.
module mix_col_word
  import aes_pkg::*;
(
  input  col_t      col_i,
  input  coef_set_t coef_i,
  output col_t      col_o
);

  logic [7:0] a    [4];
  logic [7:0] prod [4][4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r] = col_i[31-8*r -: 8];

    for (genvar k = 0; k < 4; k++) begin : g_term
      assign prod[r][k] = gf_mul4(a[(r+k)%4], coef_i[15-4*k -: 4]);
    end

    assign col_o[31-8*r -: 8] = prod[r][0] ^ prod[r][1] ^ prod[r][2] ^ prod[r][3];
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: accepts a state, mixes one column per cycle, then holds the result.
// Optional macro INV_MIX_COLUMNS_EN adds i_inverse and switches the coefficient set per state.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
`ifdef INV_MIX_COLUMNS_EN
  input  logic         i_inverse,
`endif
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data
);

  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;

  mix_state_e    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  state_t        work_q, work_d;
  state_t        out_q, out_d;
  col_t          col_word;
  col_t          mix_word;
  coef_set_t     coef_set;

`ifdef INV_MIX_COLUMNS_EN
  logic inv_q, inv_d;
  assign coef_set = inv_q ? MIX_INV : MIX_FWD;
`else
  assign coef_set = MIX_FWD;
`endif

  always_comb begin
    col_word = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (col_q == CW'(c)) col_word = work_q[127-32*c -: 32];
    end
  end

  mix_col_word u_mix (
    .col_i  (col_word),
    .coef_i (coef_set),
    .col_o  (mix_word)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    out_d   = out_q;
`ifdef INV_MIX_COLUMNS_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          work_d  = i_data;
`ifdef INV_MIX_COLUMNS_EN
          inv_d   = i_inverse;
`endif
          col_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int c = 0; c < NCOL; c++) begin
          if (col_q == CW'(c)) out_d[127-32*c -: 32] = mix_word;
        end
        if (col_q == CW'(NCOL-1)) begin
          col_d   = '0;
          state_d = DONE;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears the whole datapath so o_data reads zero immediately, even mid-state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
`ifdef INV_MIX_COLUMNS_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      out_q   <= out_d;
`ifdef INV_MIX_COLUMNS_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_data  = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: vector table plus corner sequences, scoreboard queue on accept/transfer.
`timescale 1ns/1ps
module tb_mix_columns_seq;
  import aes_pkg::*;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_data;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_data;
`ifdef INV_MIX_COLUMNS_EN
  logic         i_inverse;
`endif

  always #5 clk = ~clk;

  mix_columns_seq #(.NCOL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
`ifdef INV_MIX_COLUMNS_EN
    .i_inverse (i_inverse),
`endif
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data)
  );

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           last_acc = 0;
  int           acc_hist[$];
  logic [127:0] exp_q[$];
  logic [127:0] exp_cur;
  logic         vld_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (({x[6:0], 1'b0}) ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
    else     begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(a[(j+k)%4], m[k]);
        r[127-8*(4*c+j) -: 8] = acc;
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accept, pop on output transfer, latency on o_valid rise.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_valid && o_ready) begin
        exp_q.push_back(exp_cur);
        last_acc = cyc;
        acc_hist.push_back(cyc);
      end
      if (o_valid && !vld_prev) chk_int("latency", cyc - last_acc, 5);
      if (o_valid) chk_bit("o_ready_in_done", o_ready, 1'b0);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", o_data);
        end else begin
          chk("o_data", o_data, exp_q.pop_front());
        end
      end
    end
    vld_prev = o_valid;
  end

  task automatic put(input logic [127:0] s, input logic [127:0] e, input bit align);
    if (align) begin
      @(posedge clk);
      #1;
    end
    i_valid = 1'b1;
    i_data  = s;
    exp_cur = e;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (o_ready) begin
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: o_ready stayed 0, want 1");
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && o_ready) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d results pending, want 0", exp_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         vecs[5];
    logic [127:0] s;
    int           base;

    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    exp_cur = '0;
`ifdef INV_MIX_COLUMNS_EN
    i_inverse = 1'b0;
`endif
    @(negedge clk);
    chk_bit("reset_o_valid", o_valid, 1'b0);
    chk_bit("reset_o_ready", o_ready, 1'b1);
    chk("reset_o_data", o_data, 128'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    vecs[0] = '{din: 128'hdb135345_f20a225c_01010101_c6c6c6c6,
                dout: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vecs[1] = '{din: {4{32'h2d26314c}}, dout: {4{32'h4d7ebdf8}}};
    vecs[2] = '{din: 128'h0, dout: 128'h0};
    vecs[3] = '{din: {4{32'hd4d4d4d5}}, dout: {4{32'hd5d5d7d6}}};
    vecs[4] = '{din: 128'h2d26314c_d4d4d4d5_00000000_db135345,
                dout: 128'h4d7ebdf8_d5d5d7d6_00000000_8e4da1bc};

    for (int i = 0; i < 5; i++) begin
      put(vecs[i].din, vecs[i].dout, 1'b1);
      wait_drain();
    end

    for (int i = 0; i < 3; i++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      put(s, mix_model(s, 1'b0), 1'b1);
      wait_drain();
    end

    // Back-to-back with i_valid and i_ready held high.
    i_ready = 1'b1;
    base = acc_hist.size();
    put(vecs[0].din, vecs[0].dout, 1'b1);
    put({4{32'h2d26314c}}, {4{32'h4d7ebdf8}}, 1'b0);
    wait_drain();
    if (acc_hist.size() >= base + 2)
      chk_int("b2b_spacing", acc_hist[base+1] - acc_hist[base], 6);
    else
      chk_int("b2b_accepts", acc_hist.size() - base, 2);

    // Backpressure in DONE.
    i_ready = 1'b0;
    s = 128'h01234567_89abcdef_fedcba98_76543210;
    put(s, mix_model(s, 1'b0), 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    chk_bit("bp_reach_done", o_valid, 1'b1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk_bit("bp_o_valid", o_valid, 1'b1);
      chk_bit("bp_o_ready", o_ready, 1'b0);
      chk("bp_o_data", o_data, mix_model(s, 1'b0));
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    wait_drain();

    // Asynchronous reset while column 2 is being mixed.
    put(vecs[0].din, vecs[0].dout, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_bit("midrst_o_valid", o_valid, 1'b0);
    chk_bit("midrst_o_ready", o_ready, 1'b1);
    chk("midrst_o_data", o_data, 128'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    put(vecs[4].din, vecs[4].dout, 1'b1);
    wait_drain();

`ifdef INV_MIX_COLUMNS_EN
    i_inverse = 1'b1;
    put({4{32'h8e4da1bc}}, {4{32'hdb135345}}, 1'b1);
    i_inverse = 1'b0;
    wait_drain();
    s = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    i_inverse = 1'b1;
    put(s, mix_model(s, 1'b1), 1'b1);
    i_inverse = 1'b0;
    wait_drain();
    put(vecs[1].din, vecs[1].dout, 1'b1);
    wait_drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential AES MixColumns stage. Accepts a 128-bit cipher state via valid/ready handshake and processes one 32-bit column per cycle through a GF(2^8) constant-multiply datapath. Returns the mixed state via a second valid/ready handshake. Sits directly downstream of ShiftRows and upstream of AddRoundKey in the round pipeline. Its column datapath is built from the team's 4-bit-coefficient GF(2^8) multiplier.

## Interface
Parameters:
- NCOL, 4, number of 32-bit columns per state; fixed by AES, exposed only for the column counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  upstream offers a state on i_data.
- o_ready  out  1  block can accept a state; high only in IDLE.
- i_data  in  128  input state; byte k = i_data[127-8k -: 8]; column c = bytes 4c..4c+3; row 0 is the MSB byte.
- i_inverse  in  1  selects InvMixColumns; sampled on accept. Present only with INV_MIX_COLUMNS_EN.
- o_valid  out  1  o_data holds a complete mixed state.
- i_ready  in  1  downstream accepts o_data.
- o_data  out  128  mixed state, same byte order as i_data.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: o_ready=1. On i_valid, perform the accept:
  - load i_data into the working register;
  - latch the mode;
  - set col=0;
  - go to BUSY.
- BUSY: each cycle, compute column col combinationally:
  - forward: out_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), rows mod 4;
  - inverse coefficients (14, 11, 13, 9) in the same rotation.
  - Write the result into column col of the output register; col increments.
  - After col=NCOL-1 is written, go to DONE; col wraps to 0.
- DONE: o_valid=1; o_data stable.
  - On i_ready, complete the transfer and go to IDLE.
  - i_ready is ignored in IDLE and BUSY.
- i_valid and i_data are ignored while o_ready=0. Upstream must hold them until accepted.
- Arithmetic: all products are GF(2^8) with reduction polynomial 0x11B; additions are XOR. No carries, no width growth.
- Reset, including mid-BUSY or mid-DONE: immediately enter IDLE.
  - o_valid=0, o_ready=1, o_data=0, col=0, mode=forward.
  - The in-flight state is discarded.

## Timing
- Accept edge E (i_valid & o_ready).
- Columns 0..3 are written on edges E+1..E+4.
- o_valid is high in the cycle following E+4.
- Minimum input-to-output latency: 5 cycles from the accept cycle to the first o_valid cycle.
- With i_ready held high, DONE lasts 1 cycle and o_ready returns the cycle after. Maximum throughput is one state per 6 cycles.
- o_data changes only on BUSY write edges and on reset. It is glitch-free while o_valid=1.
- o_ready and o_valid are registered state decodes with no combinational path from i_valid or i_ready.

## Configuration
- Macro: INV_MIX_COLUMNS_EN.
- Defined:
  - i_inverse port exists and is latched on accept;
  - datapath coefficient set muxes between {2,3,1,1} and {14,11,13,9}.
- Undefined:
  - no i_inverse port and no mode register;
  - forward coefficients are constants.
- Timing is identical in both builds.

## Structure
- Shared package aes_pkg holds:
  - state_t (128-bit);
  - col_t (32-bit);
  - the FSM enum;
  - constants AES_POLY=8'h1B, MIX_FWD, MIX_INV (4×4-bit coefficient vectors).
- One sub-module: mix_col_word.
  - Combinational; 32-bit column in/out plus coefficient set.
  - Contains 16 GF(2^8) constant multipliers and an XOR tree.
  - Instantiated once; the top holds the FSM, counter and registers.

## Test plan
- Reset then single state, forward: columns db135345, f20a225c, 01010101, c6c6c6c6 -> o_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, o_valid 5 cycles after accept.
- Back-to-back states with i_ready=1 and i_valid held: second accept exactly 6 cycles after the first; o_ready low throughout BUSY/DONE; second result 4d7ebdf8 for column 2d26314c.
- Backpressure: i_ready=0 for 10 cycles in DONE -> o_valid and o_data held stable, o_ready=0; transfer on the first i_ready=1 cycle.
- Reset asserted asynchronously during BUSY col=2 -> outputs zero immediately and IDLE. The next state is processed correctly from col 0.
- With INV_MIX_COLUMNS_EN, i_inverse=1 on state 8e4da1bc repeated ×4 -> db135345 ×4. Mode changes after accept do not affect the in-flight state.
- Identity/edge columns: 00000000 -> 00000000; d4d4d4d5 -> d5d5d7d6 (forward).
